// File: rtl/csla_pkg.sv
// Shared constants, parameter checks and stage-register type for the pipelined
// carry-select adder/subtractor.
package csla_pkg;

  function automatic int ngrp(input int width, input int block);
    return width / block;
  endfunction

  function automatic int gps(input int width, input int block, input int stages);
    return ngrp(width, block) / stages;
  endfunction

  function automatic bit params_ok(input int width, input int block, input int stages);
    if (block < 1 || stages < 1 || width < block) return 1'b0;
    if ((width % block) != 0) return 1'b0;
    return (ngrp(width, block) % stages) == 0;
  endfunction

  // Control half of a stage register; the data half (partial sum, operands)
  // is WIDTH-dependent and lives beside it in the top module.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/csla_sel_group.sv
// One carry-select group: ripple adder for cin=0, BEC or second ripple adder for
// cin=1, then a carry-driven mux. SELECT=0 gives a plain ripple adder on cin.
module csla_sel_group #(
  parameter int BLOCK   = 4,
  parameter bit USE_BEC = 1'b1,
  parameter bit SELECT  = 1'b1
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic c);
    logic [BLOCK:0] r;
    logic           cc;
    r  = '0;
    cc = c;
    for (int i = 0; i < BLOCK; i++) begin
      r[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    r[BLOCK] = cc;
    return r;
  endfunction

  if (!SELECT) begin : g_plain
    assign {cout, sum} = ripple(a, b, cin);
  end else begin : g_sel
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;

    assign r0 = ripple(a, b, 1'b0);

    if (USE_BEC) begin : g_bec
      logic [BLOCK-1:0] s1;
      logic             prefix;
      // prefix ends as &sum0, so it doubles as the carry generated by the +1
      always_comb begin
        prefix = 1'b1;
        s1     = '0;
        for (int i = 0; i < BLOCK; i++) begin
          s1[i]  = r0[i] ^ prefix;
          prefix = prefix & r0[i];
        end
      end
      assign r1 = {r0[BLOCK] | prefix, s1};
    end else begin : g_dup
      assign r1 = ripple(a, b, 1'b1);
    end

    assign {cout, sum} = cin ? r1 : r0;
  end

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides; each
// register stage resolves GPS groups and hands the running carry to the next.
module csla_pipe
  import csla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int BLOCK   = 4,
  parameter int STAGES  = 2,
  parameter bit USE_BEC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int G  = gps(WIDTH, BLOCK, STAGES);
  localparam int SW = G * BLOCK;

  if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $error("csla_pipe: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK a multiple of STAGES");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  logic [WIDTH-1:0]  a_pipe    [STAGES];
  logic [WIDTH-1:0]  b_pipe    [STAGES];
  logic [WIDTH-1:0]  psum_pipe [STAGES];
  stage_ctl_t        ctl_pipe  [STAGES];
  logic [STAGES-1:0] adv;

  // A stage may load when it is empty or its contents move on this cycle
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = out_ready | ~ctl_pipe[STAGES-1].valid;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = ~ctl_pipe[k].valid | adv[k+1];
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] op_a, op_b, psum_in, psum_next;
    logic [WIDTH-1:0] a_reg, b_reg, psum_reg;
    logic [SW-1:0]    grp_sum;
    logic [G:0]       carry;
    logic             valid_in;
    stage_ctl_t       ctl_reg, ctl_next;

    if (gi == 0) begin : g_head
      assign op_a     = a;
      assign op_b     = b_eff;
      assign psum_in  = '0;
      assign carry[0] = cin_eff;
      assign valid_in = in_valid;
    end else begin : g_body
      assign op_a     = a_pipe[gi-1];
      assign op_b     = b_pipe[gi-1];
      assign psum_in  = psum_pipe[gi-1];
      assign carry[0] = ctl_pipe[gi-1].carry;
      assign valid_in = ctl_pipe[gi-1].valid;
    end

    for (gj = 0; gj < G; gj++) begin : g_grp
      localparam int LSB = gi * SW + gj * BLOCK;
      csla_sel_group #(
        .BLOCK  (BLOCK),
        .USE_BEC(USE_BEC),
        .SELECT (!(gi == 0 && gj == 0))
      ) u_grp (
        .a   (op_a[LSB +: BLOCK]),
        .b   (op_b[LSB +: BLOCK]),
        .cin (carry[gj]),
        .sum (grp_sum[gj*BLOCK +: BLOCK]),
        .cout(carry[gj+1])
      );
    end

    always_comb begin
      psum_next                = psum_in;
      psum_next[gi*SW +: SW]   = grp_sum;
      ctl_next.valid           = valid_in;
      ctl_next.carry           = carry[G];
    end

    // Operand bits below this stage's groups are don't-care downstream
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_reg  <= '0;
        a_reg    <= '0;
        b_reg    <= '0;
        psum_reg <= '0;
      end else if (adv[gi]) begin
        ctl_reg  <= ctl_next;
        a_reg    <= op_a;
        b_reg    <= op_b;
        psum_reg <= psum_next;
      end
    end

    assign a_pipe[gi]    = a_reg;
    assign b_pipe[gi]    = b_reg;
    assign psum_pipe[gi] = psum_reg;
    assign ctl_pipe[gi]  = ctl_reg;
  end

  assign in_ready  = adv[0];
  assign out_valid = ctl_pipe[STAGES-1].valid;
  assign sum       = psum_pipe[STAGES-1];
  assign cout      = ctl_pipe[STAGES-1].carry;
  // carry into the MSB is recovered from the MSB operand and sum bits
  assign ovf       = a_pipe[STAGES-1][WIDTH-1] ^ b_pipe[STAGES-1][WIDTH-1]
                   ^ psum_pipe[STAGES-1][WIDTH-1] ^ ctl_pipe[STAGES-1].carry;

endmodule

// File: tb/tb_csla_pipe.sv
// Scoreboard bench for csla_pipe: directed 32/4/2 checks (latency, stall, reset)
// plus random streams over several parameter sets with random backpressure.
module tb_csla_pipe;

  localparam int NRAND = 2000;
  localparam int NCFG  = 5;
  localparam int CW [NCFG] = '{32, 64, 64, 16, 16};
  localparam int CB [NCFG] = '{4, 8, 8, 4, 4};
  localparam int CS [NCFG] = '{2, 4, 4, 1, 1};
  localparam bit CE [NCFG] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [65:0] e;
    int          acc;
    bit          lat;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for a w-bit add (a+b+cin) or subtract (a-b)
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic c, input logic s);
    logic [64:0] mask, full;
    logic [63:0] yy;
    logic        cc, sa, sb, sr, ov;
    mask = (65'd1 << w) - 65'd1;
    yy   = s ? ~y : y;
    cc   = s ? 1'b1 : c;
    full = ({1'b0, x} & mask) + ({1'b0, yy} & mask) + 65'(cc);
    sa   = x[w-1];
    sb   = y[w-1];
    sr   = full[w-1];
    ov   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, full[w], full[63:0] & mask[63:0]};
  endfunction

  function automatic logic [65:0] exp32(input logic ov, input logic co, input logic [31:0] s);
    return {ov, co, 32'h0, s};
  endfunction

  // ---------------- directed instance (32/4/2, BEC) ----------------
  logic        d_rst, d_in_valid, d_in_ready, d_cin, d_sub;
  logic        d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [31:0] d_a, d_b, d_sum;
  sb_t         dq[$];
  bit          saw_block;

  csla_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2), .USE_BEC(1'b1)) u_dut (
    .clk(clk), .rst_n(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  initial begin
    sb_t t;
    forever begin
      @(negedge clk);
      #2;
      if (d_rst && d_out_valid && d_out_ready) begin
        if (dq.size() == 0) begin
          check("d_spurious", 66'd1, 66'd0);
        end else begin
          t = dq.pop_front();
          check("d_result", {d_ovf, d_cout, 32'h0, d_sum}, t.e);
          if (t.lat) check("d_latency", 66'(cyc - t.acc), 66'd2);
        end
      end
    end
  end

  initial begin
    bit          stall_prev;
    logic [33:0] snap;
    stall_prev = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk);
      #3;
      if (stall_prev && d_rst)
        check("d_stall_hold", {31'h0, d_out_valid, d_ovf, d_cout, d_sum}, {31'h0, 1'b1, snap});
      stall_prev = d_rst && d_out_valid && !d_out_ready;
      snap       = {d_ovf, d_cout, d_sum};
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                      input logic [65:0] e, input bit lat);
    int g = 0;
    @(negedge clk);
    d_in_valid = 1'b1;
    d_a = x; d_b = y; d_cin = c; d_sub = s;
    #1;
    while (!d_in_ready && g < 50) begin
      saw_block = 1'b1;
      @(negedge clk);
      #1;
      g++;
    end
    if (!d_in_ready) check("d_accept_timeout", 66'd0, 66'd1);
    else dq.push_back('{e, cyc, lat});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    d_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while (dq.size() != 0 && g < 50) begin
      @(negedge clk);
      #3;
      g++;
    end
    check({"drain_", tag}, 66'(dq.size()), 66'd0);
  endtask

  task automatic one(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                     input logic [65:0] e, input string tag);
    send(x, y, c, s, e, 1'b1);
    idle();
    wait_drain(tag);
  endtask

  // ---------------- random instances ----------------
  logic rst_r;

  genvar gi;
  for (gi = 0; gi < NCFG; gi++) begin : g_rnd
    localparam int W = CW[gi];
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic         done;

    csla_pipe #(.WIDTH(W), .BLOCK(CB[gi]), .STAGES(CS[gi]), .USE_BEC(CE[gi])) u_dut (
      .clk(clk), .rst_n(rst_r), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial begin
      logic [65:0] q[$];
      logic [63:0] ra, rb;
      int          n, guard;
      n = 0; guard = 0; done = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      ra = '0; rb = '0;
      wait (rst_r == 1'b1);
      while ((n < NRAND || q.size() > 0) && guard < 20000) begin
        @(negedge clk);
        guard++;
        out_ready = ($urandom_range(0, 3) != 0);
        if (n < NRAND) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          case ($urandom_range(0, 7))
            0: ra = '1;
            1: rb = '1;
            2: rb = '0;
            default: ;
          endcase
          in_valid = ($urandom_range(0, 3) != 0);
          a   = ra[W-1:0];
          b   = rb[W-1:0];
          cin = $urandom_range(0, 1) != 0;
          sub = $urandom_range(0, 1) != 0;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) check($sformatf("rnd%0d_spurious", gi), 66'd1, 66'd0);
          else check($sformatf("rnd%0d", gi), {ovf, cout, 64'(sum)}, q.pop_front());
        end
        if (in_valid && in_ready) begin
          q.push_back(model(W, ra, rb, cin, sub));
          n++;
        end
      end
      check($sformatf("rnd%0d_drain", gi), 66'(q.size()), 66'd0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    d_rst = 1'b0; rst_r = 1'b0;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
    saw_block = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 66'(d_out_valid), 66'd0);
    check("rst_outputs", 66'({d_ovf, d_cout, d_sum}), 66'd0);
    d_rst = 1'b1;
    rst_r = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 66'(d_in_ready), 66'd1);

    one(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, exp32(1'b0, 1'b1, 32'h00000000), "add_wrap");
    one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, exp32(1'b1, 1'b0, 32'h80000000), "add_ovf");
    one(32'h12345678, 32'h87654321, 1'b1, 1'b0, exp32(1'b0, 1'b0, 32'h9999999A), "add_cin");
    one(32'h00000005, 32'h00000007, 1'b0, 1'b1, exp32(1'b0, 1'b0, 32'hFFFFFFFE), "sub_neg");
    one(32'h80000000, 32'h00000001, 1'b0, 1'b1, exp32(1'b1, 1'b1, 32'h7FFFFFFF), "sub_ovf");
    one(32'h00000005, 32'h00000007, 1'b1, 1'b1, exp32(1'b0, 1'b0, 32'hFFFFFFFE), "sub_cin_ignored");

    // six back-to-back beats, out_ready low in windows 3..5
    saw_block = 1'b0;
    fork
      begin
        logic [31:0] x, y;
        logic        s;
        for (int i = 0; i < 6; i++) begin
          x = $urandom;
          y = $urandom;
          s = (i % 2) != 0;
          send(x, y, 1'b0, s, model(32, 64'(x), 64'(y), 1'b0, s), 1'b0);
        end
        idle();
      end
      begin
        for (int i = 1; i <= 8; i++) begin
          @(negedge clk);
          d_out_ready = !(i >= 3 && i <= 5);
        end
      end
    join
    d_out_ready = 1'b1;
    wait_drain("stall");
    check("stall_in_ready_drop", 66'(saw_block), 66'd1);

    // mid-stream reset with two beats in flight
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0, exp32(1'b0, 1'b0, 32'h33333333), 1'b0);
    send(32'h01010101, 32'h10101010, 1'b0, 1'b0, exp32(1'b0, 1'b0, 32'h11111111), 1'b0);
    #1;
    check("pre_rst_valid", 66'(d_out_valid), 66'd1);
    dq.delete();
    @(negedge clk);
    d_in_valid = 1'b0;
    d_rst = 1'b0;
    #1;
    check("rst_mid_valid", 66'(d_out_valid), 66'd0);
    check("rst_mid_outputs", 66'({d_ovf, d_cout, d_sum}), 66'd0);
    @(negedge clk);
    d_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("rst_no_emerge", 66'(d_out_valid), 66'd0);
    end
    one(32'h00000005, 32'h00000007, 1'b0, 1'b0, exp32(1'b0, 1'b0, 32'h0000000C), "post_rst");

    g = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done && g_rnd[4].done)
           && g < 40000) begin
      @(posedge clk);
      g++;
    end
    check("rnd_all_done",
          66'(g_rnd[0].done & g_rnd[1].done & g_rnd[2].done & g_rnd[3].done & g_rnd[4].done), 66'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
